ocp_mem_target: RTL and testbench
=================================

# ocp_mem_target

OCP slave target that sits directly downstream of the AXI-to-OCP interconnect and consumes the OCP command stream on its master port. It services single-beat reads and writes into an on-chip word memory with byte enables. Every command returns exactly one response after a fixed pipeline latency, through a small response buffer with its own handshake. Command acceptance is throttled so the buffer can never overflow.

## Interface
- ADDR_W, 32, MAddr width (byte address)
- DATA_W, 32, data width; must be 32 (4 byte lanes)
- DEPTH, 256, memory depth in words; power of two
- RD_LAT, 2, cycles from command accept to response entering the buffer; 1..4
- RESP_DEPTH, 4, response buffer entries; power of two

- clk  in  1  clock (clkrst_if.clk)
- rstn  in  1  reset; synchronous, active-low (clkrst_if.rstn)
- MCmd  in  3  0=IDLE, 1=WR, 2=RD, others illegal
- MAddr  in  ADDR_W  byte address
- MData  in  DATA_W  write data
- MByteEn  in  4  write byte lanes
- SCmdAccept  out  1  command accepted this cycle
- SResp  out  2  0=NULL, 1=DVA, 3=ERR
- SData  out  DATA_W  read data; 0 for writes and errors
- MRespAccept  in  1  master consumes the presented response

## Operation
- Accept: command taken on a rising edge where MCmd!=IDLE and SCmdAccept=1.
- SCmdAccept = (outstanding < RESP_DEPTH), registered. outstanding = responses in the latency pipe plus responses in the buffer.
- Decode: idx = MAddr[ADDR_W-1:2].
  - ERR if MAddr[1:0]!=0, idx>=DEPTH, or MCmd illegal.
  - ERR commands never touch memory. They still produce a response, with SData=0.
- WR: the memory word updates on the accept edge, only for lanes with MByteEn=1. MByteEn=0 is legal and responds DVA. Response is DVA with SData=0.
- RD: data is sampled at the accept edge. Response is DVA with the memory word. Read-after-write to the same address on the next command returns the new data.
- Latency pipe: an RD_LAT-stage shift register of {valid, resp, data}. Its output pushes into the response buffer.
- Response buffer: a FIFO with RESP_DEPTH entries.
  - Its head drives SResp/SData. SResp=NULL when empty.
  - Pop when MRespAccept=1 and SResp!=NULL.
  - Responses return in strict command order.
- Counter: outstanding increments on accept and decrements on pop. Accept and pop in the same cycle leave it unchanged. It never exceeds RESP_DEPTH, so the buffer cannot overflow.

## Timing
- Reset (rstn=0 at an edge): SCmdAccept=0, SResp=NULL, SData=0. The pipe, buffer and counter are cleared. Memory contents are undefined or retained and are not cleared.
- Reset mid-operation discards all pending responses. SCmdAccept rises on the first edge after rstn returns high.
- Response latency: a command accepted at edge N is presented at edge N+RD_LAT+1 if the buffer is empty.
- Back-to-back accepts are allowed every cycle while outstanding<RESP_DEPTH. Throughput is 1 command/cycle with MRespAccept held high.
- Buffer full with MRespAccept=0: SCmdAccept drops after the edge at which outstanding reaches RESP_DEPTH. It rises one cycle after the next pop.
- SResp/SData hold stable until popped.
- The memory has one write port and one read port. A write and a read never address the same word in the same cycle, because only one command is accepted per cycle.

## Structure
- Shared package ocp_pkg:
  - mcmd_e enum (IDLE/WR/RD)
  - sresp_e enum (NULL/DVA/ERR)
  - ocp_resp_t struct {sresp_e resp; logic [31:0] data}
  - byte-lane constant 4
- Sub-module ocp_resp_fifo, parameterised by RESP_DEPTH and ocp_resp_t:
  - push/pop/full/empty
  - synchronous active-low reset
  - pointers with a wrap bit
- The top holds the decode, memory array, latency pipe and outstanding counter.

## Test plan
- WR 0x10 data 0xDEADBEEF, MByteEn=0xF; then RD 0x10 -> two DVA responses, the second with SData=0xDEADBEEF, each RD_LAT+1 cycles after its accept.
- WR 0x20 0xFFFFFFFF; WR 0x20 0x00000000 with MByteEn=0x5; RD 0x20 -> SData=0xFF00FF00.
- RD 0x403 (unaligned), RD 0x400 (idx 256 ≥ DEPTH), MCmd=5 -> three ERR responses with SData=0; memory unchanged.
- MRespAccept=0, issue 6 RDs back-to-back -> exactly 4 accepted and SCmdAccept=0. Then MRespAccept=1 -> the remaining 2 are accepted and all 6 responses arrive in order.
- Continuous RD/WR stream with MRespAccept=1 -> SCmdAccept stays 1 and one response per cycle after the initial latency.
- Assert rstn=0 with 3 responses pending -> SResp=NULL next cycle. No stale response appears after release, and the first new RD returns the correct data.

Source files
------------

// File: rtl/ocp_pkg.sv
// ocp_pkg -- shared OCP definitions for the memory target slice.
//   mcmd_e        : master command encoding (IDLE/WR/RD; other codes are illegal)
//   sresp_e       : slave response encoding (NULL/DVA/ERR)
//   ocp_resp_t    : one buffered response {resp, data}
//   merge_bytes() : byte-lane write merge used by the memory write port
package ocp_pkg;

  localparam int unsigned OCP_BYTE_LANES = 4;
  localparam int unsigned OCP_DATA_W     = 32;

  typedef enum logic [2:0] {
    MCMD_IDLE = 3'd0,
    MCMD_WR   = 3'd1,
    MCMD_RD   = 3'd2
  } mcmd_e;

  typedef enum logic [1:0] {
    SRESP_NULL = 2'd0,
    SRESP_DVA  = 2'd1,
    SRESP_ERR  = 2'd3
  } sresp_e;

  typedef struct packed {
    sresp_e      resp;
    logic [31:0] data;
  } ocp_resp_t;

  localparam ocp_resp_t OCP_RESP_ZERO = '{resp: SRESP_NULL, data: 32'h0000_0000};

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[b*8 +: 8] = new_w[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_w[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ocp_mem_target_if.sv
// ocp_mem_target_if -- OCP command/response bundle between the interconnect
// (master) and the memory target (slave).
//   MCmd/MAddr/MData/MByteEn : command from master
//   SCmdAccept               : slave takes the command this cycle
//   SResp/SData              : response at the head of the slave buffer
//   MRespAccept              : master consumes the presented response
interface ocp_mem_target_if
  import ocp_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic [2:0]                MCmd;
  logic [ADDR_W-1:0]         MAddr;
  logic [DATA_W-1:0]         MData;
  logic [OCP_BYTE_LANES-1:0] MByteEn;
  logic                      SCmdAccept;
  logic [1:0]                SResp;
  logic [DATA_W-1:0]         SData;
  logic                      MRespAccept;

  modport master (
    output MCmd, MAddr, MData, MByteEn, MRespAccept,
    input  SCmdAccept, SResp, SData
  );

  modport slave (
    input  MCmd, MAddr, MData, MByteEn, MRespAccept,
    output SCmdAccept, SResp, SData
  );

endinterface

// File: rtl/ocp_resp_fifo.sv
// ocp_resp_fifo -- response buffer for the OCP memory target.
//   clk, rstn       : clock, synchronous active-low reset
//   push, push_data : enqueue one response (ignored when full)
//   pop             : dequeue the head (ignored when empty)
//   full, empty     : occupancy flags
//   head            : oldest entry, valid while !empty
// Pointers carry an extra wrap bit so full and empty are distinguishable
// when the index parts are equal.
module ocp_resp_fifo
  import ocp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = ocp_resp_t
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  T            mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        do_push_s;
  logic        do_pop_s;

  // Occupancy flags, guarded push/pop and head read-out
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    head      = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Entry storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/ocp_mem_target.sv
// ocp_mem_target -- OCP slave serving single-beat reads/writes into an
// on-chip word memory with byte enables.
//   clk, rstn : clock, synchronous active-low reset
//   ocp       : OCP slave bundle (command in, SCmdAccept, SResp/SData out,
//               MRespAccept in)
// Every accepted command (including errored ones) travels through an
// RD_LAT-deep pipe into a RESP_DEPTH-entry buffer. Commands are only
// accepted while outstanding responses (pipe + buffer) < RESP_DEPTH, so the
// buffer cannot overflow.
module ocp_mem_target
  import ocp_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned RESP_DEPTH = 4
) (
  input logic               clk,
  input logic               rstn,
  ocp_mem_target_if.slave   ocp
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESP_DEPTH);

  logic [31:0]       mem_r [DEPTH];

  logic [IDX_W-1:0]  idx_s;
  logic              addr_hi_nz_s;
  logic              is_wr_s;
  logic              is_rd_s;
  logic              err_s;
  logic              accept_s;
  logic              wr_en_s;
  ocp_resp_t         stage_in_s;

  logic [RD_LAT-1:0] pipe_vld_r;
  ocp_resp_t         pipe_r [RD_LAT];

  logic              push_s;
  logic              pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  ocp_resp_t         fifo_head_s;

  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              scmd_accept_r;

  // Any set address bit above the word index means idx >= DEPTH.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_addr_hi
      assign addr_hi_nz_s = |ocp.MAddr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_addr_hi
      assign addr_hi_nz_s = 1'b0;
    end
  endgenerate

  // Command decode, error classification and pipe stage-0 payload
  always_comb begin
    idx_s    = ocp.MAddr[IDX_W+1:2];
    is_wr_s  = (ocp.MCmd == MCMD_WR);
    is_rd_s  = (ocp.MCmd == MCMD_RD);
    err_s    = (ocp.MAddr[1:0] != 2'b00) || addr_hi_nz_s || !(is_wr_s || is_rd_s);
    // rstn gates accept so a command on a reset edge never writes memory
    accept_s = rstn && scmd_accept_r && (ocp.MCmd != MCMD_IDLE);
    wr_en_s  = accept_s && is_wr_s && !err_s;
    stage_in_s.resp = err_s ? SRESP_ERR : SRESP_DVA;
    if (is_rd_s && !err_s) begin
      stage_in_s.data = mem_r[idx_s];
    end else begin
      stage_in_s.data = 32'h0000_0000;
    end
  end

  // Memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[idx_s] <= merge_bytes(mem_r[idx_s], ocp.MData, ocp.MByteEn);
    end
  end

  // Latency pipe: one stage per cycle, valid travels with its response
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pipe_vld_r <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_r[i] <= OCP_RESP_ZERO;
      end
    end else begin
      pipe_vld_r[0] <= accept_s;
      pipe_r[0]     <= stage_in_s;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_r[i]     <= pipe_r[i-1];
      end
    end
  end

  // Buffer handshake
  always_comb begin
    push_s = pipe_vld_r[RD_LAT-1] && !fifo_full_s;
    pop_s  = ocp.MRespAccept && !fifo_empty_s;
  end

  ocp_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .T     (ocp_resp_t)
  ) u_resp_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_s),
    .push_data (pipe_r[RD_LAT-1]),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (fifo_head_s)
  );

  // Outstanding-count update: accept and pop together cancel
  always_comb begin
    cnt_next_s = cnt_r;
    case ({accept_s, pop_s})
      2'b10:   cnt_next_s = cnt_r + CNT_ONE;
      2'b01:   cnt_next_s = cnt_r - CNT_ONE;
      default: cnt_next_s = cnt_r;
    endcase
  end

  // Outstanding counter and SCmdAccept, computed from the next count so
  // acceptance drops on the same edge the last free slot is taken
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_r         <= {CNT_W{1'b0}};
      scmd_accept_r <= 1'b0;
    end else begin
      cnt_r         <= cnt_next_s;
      scmd_accept_r <= (cnt_next_s < CNT_MAX);
    end
  end

  assign ocp.SCmdAccept = scmd_accept_r;
  assign ocp.SResp      = fifo_empty_s ? SRESP_NULL : fifo_head_s.resp;
  assign ocp.SData      = fifo_empty_s ? {DATA_W{1'b0}} : fifo_head_s.data;

endmodule

// File: tb/tb_ocp_mem_target.sv
// tb_ocp_mem_target -- self-checking bench for ocp_mem_target.
// Directed vector table for single commands, plus hand-written sequences for
// back-pressure, streaming and mid-operation reset.
module tb_ocp_mem_target;
  import ocp_pkg::*;

  localparam int RD_LAT     = 2;
  localparam int RESP_DEPTH = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  ocp_mem_target_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ocp_mem_target #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .DEPTH      (256),
    .RD_LAT     (RD_LAT),
    .RESP_DEPTH (RESP_DEPTH)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .ocp  (bus)
  );

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one command, wait for accept, then check response, data and the
  // edge (relative to the accept edge) at which the master pops it.
  task automatic run_vec(input vec_t v);
    int waitc;
    int lat;
    bit got;
    @(negedge clk);
    bus.MCmd        = v.cmd;
    bus.MAddr       = v.addr;
    bus.MData       = v.wdata;
    bus.MByteEn     = v.be;
    bus.MRespAccept = 1'b1;
    waitc = 0;
    while (!bus.SCmdAccept && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.SCmdAccept) begin
      check("vec_accept_timeout", 32'd0, 32'd1);
      bus.MCmd = 3'd0;
      return;
    end
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      if (lat == 0) bus.MCmd = 3'd0;
      lat++;
      if (bus.SResp != 2'd0) got = 1'b1;
    end
    check("vec_resp_seen", {31'd0, got}, 32'd1);
    check("vec_resp", {30'd0, bus.SResp}, {30'd0, v.exp_resp});
    check("vec_data", bus.SData, v.exp_data);
    check("vec_latency", lat, RD_LAT + 1);
    @(posedge clk);
    @(negedge clk);
    check("vec_popped", {30'd0, bus.SResp}, 32'd0);
  endtask

  vec_t vecs [17];

  logic [31:0] bp_addr [6];
  logic [31:0] bp_exp  [6];
  logic [2:0]  st_cmd  [8];
  logic [31:0] st_addr [8];
  logic [31:0] st_data [8];
  logic [31:0] st_exp  [8];

  initial begin
    int j;
    int k;
    int c;
    int drops;
    int bad_gap;
    int stale;
    int resp_cyc [8];
    bit will;

    vecs[0]  = '{3'd1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'd1, 32'h0000_0000};
    vecs[1]  = '{3'd2, 32'h0000_0010, 32'h0000_0000, 4'hF, 2'd1, 32'hDEAD_BEEF};
    vecs[2]  = '{3'd1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 2'd1, 32'h0000_0000};
    vecs[3]  = '{3'd1, 32'h0000_0020, 32'h0000_0000, 4'h5, 2'd1, 32'h0000_0000};
    vecs[4]  = '{3'd2, 32'h0000_0020, 32'h0000_0000, 4'hF, 2'd1, 32'hFF00_FF00};
    vecs[5]  = '{3'd2, 32'h0000_0403, 32'h0000_0000, 4'hF, 2'd3, 32'h0000_0000};
    vecs[6]  = '{3'd2, 32'h0000_0400, 32'h0000_0000, 4'hF, 2'd3, 32'h0000_0000};
    vecs[7]  = '{3'd5, 32'h0000_0010, 32'h1234_5678, 4'hF, 2'd3, 32'h0000_0000};
    vecs[8]  = '{3'd1, 32'h0000_0013, 32'h1111_1111, 4'hF, 2'd3, 32'h0000_0000};
    vecs[9]  = '{3'd2, 32'h0000_0010, 32'h0000_0000, 4'hF, 2'd1, 32'hDEAD_BEEF};
    vecs[10] = '{3'd2, 32'h0000_0020, 32'h0000_0000, 4'hF, 2'd1, 32'hFF00_FF00};
    vecs[11] = '{3'd1, 32'h0000_03FC, 32'hCAFE_F00D, 4'hF, 2'd1, 32'h0000_0000};
    vecs[12] = '{3'd1, 32'h0000_03FC, 32'h0000_0000, 4'h0, 2'd1, 32'h0000_0000};
    vecs[13] = '{3'd2, 32'h0000_03FC, 32'h0000_0000, 4'hF, 2'd1, 32'hCAFE_F00D};
    vecs[14] = '{3'd1, 32'h0000_03FC, 32'h1234_5678, 4'hA, 2'd1, 32'h0000_0000};
    vecs[15] = '{3'd2, 32'h0000_03FC, 32'h0000_0000, 4'hF, 2'd1, 32'h12FE_560D};
    vecs[16] = '{3'd2, 32'h8000_0010, 32'h0000_0000, 4'hF, 2'd3, 32'h0000_0000};

    bp_addr = '{32'h10, 32'h20, 32'h3FC, 32'h10, 32'h20, 32'h3FC};
    bp_exp  = '{32'hDEAD_BEEF, 32'hFF00_FF00, 32'h12FE_560D,
                32'hDEAD_BEEF, 32'hFF00_FF00, 32'h12FE_560D};

    st_cmd  = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd2, 3'd2};
    st_addr = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h40, 32'h40, 32'h44, 32'h10};
    st_data = '{32'hA0A0_A0A0, 32'h0, 32'hA1A1_A1A1, 32'h0, 32'hB0B0_B0B0, 32'h0, 32'h0, 32'h0};
    st_exp  = '{32'h0, 32'hA0A0_A0A0, 32'h0, 32'hA1A1_A1A1, 32'h0, 32'hB0B0_B0B0,
                32'hA1A1_A1A1, 32'hDEAD_BEEF};

    // ---------------- reset state ----------------
    bus.MCmd        = 3'd0;
    bus.MAddr       = 32'h0;
    bus.MData       = 32'h0;
    bus.MByteEn     = 4'h0;
    bus.MRespAccept = 1'b0;
    rstn            = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmdaccept", {31'd0, bus.SCmdAccept}, 32'd0);
    check("rst_sresp", {30'd0, bus.SResp}, 32'd0);
    check("rst_sdata", bus.SData, 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_release_accept", {31'd0, bus.SCmdAccept}, 32'd1);

    // ---------------- directed vectors ----------------
    for (int i = 0; i < 17; i++) begin
      run_vec(vecs[i]);
    end

    // ---------------- back-pressure: 6 RDs, buffer holds 4 ----------------
    @(negedge clk);
    bus.MRespAccept = 1'b0;
    j = 0;
    for (int cy = 0; cy < 10; cy++) begin
      if (cy > 0) @(negedge clk);
      if (j < 6) begin
        bus.MCmd  = 3'd2;
        bus.MAddr = bp_addr[j];
      end else begin
        bus.MCmd = 3'd0;
      end
      will = (j < 6) && bus.SCmdAccept;
      @(posedge clk);
      if (will) j++;
    end
    @(negedge clk);
    check("bp_accepted_count", j, 4);
    check("bp_cmdaccept_low", {31'd0, bus.SCmdAccept}, 32'd0);
    check("bp_head_resp", {30'd0, bus.SResp}, 32'd1);
    check("bp_head_data", bus.SData, bp_exp[0]);
    bus.MRespAccept = 1'b1;
    k = 0;
    c = 0;
    while (k < 6 && c < 40) begin
      if (j < 6) begin
        bus.MCmd  = 3'd2;
        bus.MAddr = bp_addr[j];
      end else begin
        bus.MCmd = 3'd0;
      end
      will = (j < 6) && bus.SCmdAccept;
      if (bus.SResp != 2'd0) begin
        check("bp_resp", {30'd0, bus.SResp}, 32'd1);
        check("bp_data", bus.SData, bp_exp[k]);
        k++;
      end
      @(posedge clk);
      if (will) j++;
      @(negedge clk);
      c++;
    end
    bus.MCmd = 3'd0;
    check("bp_all_accepted", j, 6);
    check("bp_all_responses", k, 6);

    // ---------------- continuous stream ----------------
    j = 0;
    k = 0;
    drops = 0;
    for (int cy = 0; cy < 30 && k < 8; cy++) begin
      @(negedge clk);
      if (j < 8) begin
        bus.MCmd    = st_cmd[j];
        bus.MAddr   = st_addr[j];
        bus.MData   = st_data[j];
        bus.MByteEn = 4'hF;
        if (!bus.SCmdAccept) drops++;
      end else begin
        bus.MCmd = 3'd0;
      end
      if (bus.SResp != 2'd0) begin
        check("st_resp", {30'd0, bus.SResp}, 32'd1);
        check("st_data", bus.SData, st_exp[k]);
        resp_cyc[k] = cy;
        k++;
      end
      will = (j < 8) && bus.SCmdAccept;
      @(posedge clk);
      if (will) j++;
    end
    bus.MCmd = 3'd0;
    check("st_accept_drops", drops, 0);
    check("st_resp_count", k, 8);
    if (k > 0) begin
      check("st_first_latency", resp_cyc[0], RD_LAT + 1);
      bad_gap = 0;
      for (int i = 1; i < k; i++) begin
        if (resp_cyc[i] != resp_cyc[i-1] + 1) bad_gap++;
      end
      check("st_one_per_cycle", bad_gap, 0);
    end

    // ---------------- reset with pending responses ----------------
    @(negedge clk);
    bus.MRespAccept = 1'b0;
    bus.MCmd        = 3'd2;
    bus.MAddr       = 32'h10;
    j = 0;
    for (int cy = 0; cy < 8 && j < 3; cy++) begin
      will = bus.SCmdAccept;
      @(posedge clk);
      if (will) j++;
      @(negedge clk);
    end
    bus.MCmd = 3'd0;
    repeat (3) @(negedge clk);
    check("rst2_pending", {30'd0, bus.SResp}, 32'd1);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst2_sresp_null", {30'd0, bus.SResp}, 32'd0);
    check("rst2_sdata_zero", bus.SData, 32'h0);
    check("rst2_cmdaccept_low", {31'd0, bus.SCmdAccept}, 32'd0);
    rstn            = 1'b1;
    bus.MRespAccept = 1'b1;
    @(negedge clk);
    check("rst2_release_accept", {31'd0, bus.SCmdAccept}, 32'd1);
    stale = 0;
    for (int cy = 0; cy < 6; cy++) begin
      @(negedge clk);
      if (bus.SResp != 2'd0) stale++;
    end
    check("rst2_no_stale", stale, 0);
    run_vec('{3'd2, 32'h0000_03FC, 32'h0, 4'hF, 2'd1, 32'h12FE_560D});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
